// File: rtl/ps2_key_ctrl_if.sv
// Event bus between the ps2 receiver, the key controller and the enigma core.
// slave : the key controller (consumes bytes, produces events)
// master: the surrounding logic (produces bytes, consumes events)
interface ps2_key_ctrl_if;
  logic       key_rdy;
  logic [7:0] key_out;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_type;
  logic [4:0] evt_idx;
  logic       ovf;
  logic       tmo_err;

  modport slave (
    input  key_rdy, key_out, evt_ready,
    output evt_valid, evt_type, evt_idx, ovf, tmo_err
  );

  modport master (
    output key_rdy, key_out, evt_ready,
    input  evt_valid, evt_type, evt_idx, ovf, tmo_err
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 set-2 key sequencer: strips E0/F0 prefix sequences, decodes letter and
// command makes into events, and holds one event for a valid/ready consumer.
// Optional macro PS2_REPEAT_FILTER_EN suppresses typematic repeats of the
// last decodable make until its break code is seen.
module ps2_key_ctrl #(
  parameter int TIMEOUT_CYC = 100000,
  parameter int TMO_W       = 17
) (
  input  logic            clk,
  input  logic            rst,
  ps2_key_ctrl_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;

  state_t           state, state_nx;
  logic [TMO_W-1:0] tmo_cnt;
  logic             expire;
  logic             make_hit;   // decodable make byte arriving in IDLE
  logic             brk_byte;   // byte completing a plain break sequence
  logic             suppress;   // repeat of the held key
  logic             dec_hit;
  logic [1:0]       dec_type;
  logic [4:0]       dec_idx;

  // {hit, type, idx} for a scan code
  function automatic logic [7:0] decode(input logic [7:0] c);
    logic [7:0] r;
    r = 8'h00;
    case (c)
      8'h1C: r = {1'b1, 2'd0, 5'd0};   8'h32: r = {1'b1, 2'd0, 5'd1};
      8'h21: r = {1'b1, 2'd0, 5'd2};   8'h23: r = {1'b1, 2'd0, 5'd3};
      8'h24: r = {1'b1, 2'd0, 5'd4};   8'h2B: r = {1'b1, 2'd0, 5'd5};
      8'h34: r = {1'b1, 2'd0, 5'd6};   8'h33: r = {1'b1, 2'd0, 5'd7};
      8'h43: r = {1'b1, 2'd0, 5'd8};   8'h3B: r = {1'b1, 2'd0, 5'd9};
      8'h42: r = {1'b1, 2'd0, 5'd10};  8'h4B: r = {1'b1, 2'd0, 5'd11};
      8'h3A: r = {1'b1, 2'd0, 5'd12};  8'h31: r = {1'b1, 2'd0, 5'd13};
      8'h44: r = {1'b1, 2'd0, 5'd14};  8'h4D: r = {1'b1, 2'd0, 5'd15};
      8'h15: r = {1'b1, 2'd0, 5'd16};  8'h2D: r = {1'b1, 2'd0, 5'd17};
      8'h1B: r = {1'b1, 2'd0, 5'd18};  8'h2C: r = {1'b1, 2'd0, 5'd19};
      8'h3C: r = {1'b1, 2'd0, 5'd20};  8'h2A: r = {1'b1, 2'd0, 5'd21};
      8'h1D: r = {1'b1, 2'd0, 5'd22};  8'h22: r = {1'b1, 2'd0, 5'd23};
      8'h35: r = {1'b1, 2'd0, 5'd24};  8'h1A: r = {1'b1, 2'd0, 5'd25};
      8'h5A: r = {1'b1, 2'd1, 5'd0};
      8'h66: r = {1'b1, 2'd2, 5'd0};
      8'h76: r = {1'b1, 2'd3, 5'd0};
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  assign {dec_hit, dec_type, dec_idx} = decode(bus.key_out);

  // A byte in the same cycle as expiry wins over the timeout
  assign expire = (state != IDLE) && !bus.key_rdy &&
                  (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: prefix tracking on each byte, abort to IDLE on timeout
  always_comb begin
    state_nx = state;
    if (bus.key_rdy) begin
      case (state)
        IDLE:    if (bus.key_out == CODE_E0)      state_nx = EXT;
                 else if (bus.key_out == CODE_F0) state_nx = BRK;
        EXT:     state_nx = (bus.key_out == CODE_F0) ? EXT_BRK : IDLE;
        default: state_nx = IDLE;
      endcase
    end else if (expire) begin
      state_nx = IDLE;
    end
  end

  // FSM outputs: which byte is a make to emit, which completes a break
  always_comb begin
    make_hit = 1'b0;
    brk_byte = 1'b0;
    if (bus.key_rdy) begin
      make_hit = (state == IDLE) && dec_hit;   // E0/F0 never decode
      brk_byte = (state == BRK);
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic [7:0] held;
  logic       held_vld;

  assign suppress = held_vld && (bus.key_out == held);

  // Remember the last decodable make; its break re-arms the key
  always_ff @(posedge clk) begin
    if (rst) begin
      held     <= 8'h00;
      held_vld <= 1'b0;
    end else if (make_hit && !suppress) begin
      held     <= bus.key_out;
      held_vld <= 1'b1;
    end else if (brk_byte && suppress) begin
      held_vld <= 1'b0;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  // Prefix timeout counter; runs only while a prefix is pending
  always_ff @(posedge clk) begin
    if (rst)                                  tmo_cnt <= '0;
    else if (bus.key_rdy || state == IDLE || expire) tmo_cnt <= '0;
    else                                      tmo_cnt <= tmo_cnt + 1'b1;
  end

  // One-entry event register with drop-and-flag on overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.evt_valid <= 1'b0;
      bus.evt_type  <= 2'd0;
      bus.evt_idx   <= 5'd0;
      bus.ovf       <= 1'b0;
      bus.tmo_err   <= 1'b0;
    end else begin
      bus.tmo_err <= expire;
      if (make_hit && !suppress) begin
        if (!bus.evt_valid || bus.evt_ready) begin
          bus.evt_valid <= 1'b1;
          bus.evt_type  <= dec_type;
          bus.evt_idx   <= dec_idx;
        end else begin
          bus.ovf <= 1'b1;
        end
      end else if (bus.evt_valid && bus.evt_ready) begin
        bus.evt_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Self-checking bench for ps2_key_ctrl: directed scenarios plus random byte
// streams, compared cycle by cycle against a byte-level behavioural model.
module tb_ps2_key_ctrl;
  localparam int T = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  ps2_key_ctrl_if bus();

  ps2_key_ctrl #(.TIMEOUT_CYC(T), .TMO_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int hs_cnt = 0, tmo_seen = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  byte unsigned letters[26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,
                                8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,
                                8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
  bit         m_ext, m_brk;     // prefixes seen so far
  int         m_quiet;          // edges with prefix pending and no byte
  bit         m_v, m_ovf, m_tmo;
  int         m_type, m_idx;
  bit         m_hv;
  byte unsigned m_held;

  function automatic bit lookup(input byte unsigned b, output int ty, output int ix);
    ty = 0; ix = 0;
    for (int i = 0; i < 26; i++) if (letters[i] == b) begin ix = i; return 1'b1; end
    if (b == 8'h5A) begin ty = 1; return 1'b1; end
    if (b == 8'h66) begin ty = 2; return 1'b1; end
    if (b == 8'h76) begin ty = 3; return 1'b1; end
    return 1'b0;
  endfunction

  task automatic model_edge(input bit r, input bit kr, input byte unsigned b, input bit rdy);
    bit emit; int ty, ix;
    emit = 0; ty = 0; ix = 0;
    if (r) begin
      m_ext = 0; m_brk = 0; m_quiet = 0; m_v = 0; m_ovf = 0; m_tmo = 0;
      m_type = 0; m_idx = 0; m_hv = 0; m_held = 0;
      return;
    end
    m_tmo = 0;
    if (kr) begin
      m_quiet = 0;
      if (!m_ext && !m_brk) begin
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else if (lookup(b, ty, ix)) begin
          emit = 1;
`ifdef PS2_REPEAT_FILTER_EN
          if (m_hv && m_held == b) emit = 0;
          else begin m_held = b; m_hv = 1; end
`endif
        end
      end else if (m_ext && !m_brk) begin
        if (b == 8'hF0) m_brk = 1; else m_ext = 0;
      end else if (m_brk && !m_ext) begin
        if (m_hv && m_held == b) m_hv = 0;
        m_brk = 0;
      end else begin
        m_ext = 0; m_brk = 0;
      end
    end else if (m_ext || m_brk) begin
      if (m_quiet == T - 1) begin m_ext = 0; m_brk = 0; m_quiet = 0; m_tmo = 1; end
      else m_quiet++;
    end
    if (emit) begin
      if (!m_v || rdy) begin m_v = 1; m_type = ty; m_idx = ix; end
      else m_ovf = 1;
    end else if (m_v && rdy) m_v = 0;
  endtask

  // One clock: drive at negedge, update model at posedge, compare just after
  task automatic step(input bit r, input bit kr, input byte unsigned b, input bit rdy);
    logic [15:0] got, exp;
    @(negedge clk);
    rst = r; bus.key_rdy = kr; bus.key_out = b; bus.evt_ready = rdy;
    if (!r && bus.evt_valid && rdy) hs_cnt++;
    if (bus.tmo_err) tmo_seen++;
    @(posedge clk);
    model_edge(r, kr, b, rdy);
    #1;
    got = {6'd0, bus.evt_valid, bus.evt_valid ? {bus.evt_type, bus.evt_idx} : 7'd0,
           bus.ovf, bus.tmo_err};
    exp = {6'd0, m_v, m_v ? {m_type[1:0], m_idx[4:0]} : 7'd0, m_ovf, m_tmo};
    chk("cycle", got, exp);
  endtask

  task automatic send(input byte unsigned b);
    step(0, 1, b, 1);
    step(0, 0, 8'h00, 1);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, rdy);
  endtask

  function automatic byte unsigned rand_byte();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0, 1, 2, 3: return letters[$urandom_range(0, 25)];
      4:          return ($urandom_range(0, 2) == 0) ? 8'h5A :
                         ($urandom_range(0, 1) == 0) ? 8'h66 : 8'h76;
      5:          return 8'hE0;
      6, 7:       return 8'hF0;
      8:          return ($urandom_range(0, 1) == 0) ? 8'hAA : 8'hFA;
      default:    return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    bus.key_rdy = 0; bus.key_out = 0; bus.evt_ready = 0;
    step(1, 0, 8'h00, 0);
    step(1, 1, 8'h1C, 1);   // byte under reset is lost
    chk("rst_valid", 16'(bus.evt_valid), 16'd0);
    chk("rst_ovf",   16'(bus.ovf), 16'd0);

    // make / break / make: one event only
    hs_cnt = 0;
    step(0, 1, 8'h1C, 1);
    chk("lat_valid", 16'(bus.evt_valid), 16'd1);
    chk("lat_idx",   16'(bus.evt_idx), 16'd0);
    idle(1, 1); send(8'hF0); send(8'h1C); idle(2, 1);
    chk("mbm_cnt", 16'(hs_cnt), 16'd1);

    // letters and commands in order
    step(1, 0, 8'h00, 1);
    hs_cnt = 0;
    send(8'h15); send(8'h5A); send(8'h76); send(8'h66); send(8'h1A); idle(2, 1);
    chk("seq_cnt", 16'(hs_cnt), 16'd5);
    chk("seq_ovf", 16'(bus.ovf), 16'd0);

    // extended make and extended break: nothing emitted
    hs_cnt = 0;
    send(8'hE0); send(8'h5A); send(8'hE0); send(8'hF0); send(8'h5A); idle(2, 1);
    chk("ext_cnt", 16'(hs_cnt), 16'd0);

    // break prefix timeout, then a make is a make again
    tmo_seen = 0;
    step(0, 1, 8'hF0, 1); idle(T + 4, 1);
    chk("tmo_cnt", 16'(tmo_seen), 16'd1);
    step(0, 1, 8'h1C, 1);
    chk("tmo_after", 16'({bus.evt_valid, bus.evt_idx}), 16'({1'b1, 5'd0}));
    idle(2, 1);

    // byte on the expiry cycle wins over the timeout
    tmo_seen = 0;
    step(0, 1, 8'hF0, 1); idle(T - 1, 1); step(0, 1, 8'h1C, 1); idle(T + 2, 1);
    chk("tmo_race", 16'(tmo_seen), 16'd0);

    // overflow and drain-with-load
    step(0, 1, 8'h1C, 0); step(0, 1, 8'h32, 0);
    chk("ovf_idx", 16'(bus.evt_idx), 16'd0);
    chk("ovf_flag", 16'(bus.ovf), 16'd1);
    step(0, 1, 8'h21, 1);
    chk("drain_load", 16'({bus.evt_valid, bus.evt_idx}), 16'({1'b1, 5'd2}));
    idle(2, 1);

    // typematic repeats
    step(1, 0, 8'h00, 1);
    hs_cnt = 0;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C); idle(2, 1);
`ifdef PS2_REPEAT_FILTER_EN
    chk("rep_cnt", 16'(hs_cnt), 16'd2);
`else
    chk("rep_cnt", 16'(hs_cnt), 16'd4);
`endif

    // reset in the middle of an extended sequence
    step(0, 1, 8'h32, 0); step(0, 1, 8'h1D, 0);
    step(0, 1, 8'hE0, 0); step(1, 1, 8'h5A, 0);
    chk("mid_rst", 16'({bus.evt_valid, bus.evt_type, bus.evt_idx, bus.ovf, bus.tmo_err}), 16'd0);
    step(0, 1, 8'h1C, 1);
    chk("mid_rst_nx", 16'({bus.evt_valid, bus.evt_idx}), 16'({1'b1, 5'd0}));

    // random streams with random gaps, back-pressure and occasional resets
    for (int i = 0; i < 3000; i++) begin
      int g;
      g = $urandom_range(0, 19);
      if (g == 0)      step(1, $urandom_range(0, 1), rand_byte(), $urandom_range(0, 1));
      else if (g < 12) step(0, 1, rand_byte(), $urandom_range(0, 3) != 0);
      else if (g < 19) step(0, 0, 8'h00, $urandom_range(0, 3) != 0);
      else             idle($urandom_range(T - 2, T + 3), $urandom_range(0, 1));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/ps2_key_ctrl.md
Name: ps2_key_ctrl

Overview:
- Sequences the byte stream from the ps2 receiver (key_rdy/key_out) into clean key events for the enigma core.
- Tracks PS/2 set-2 prefix bytes (E0 extended, F0 break) with an FSM and discards break and extended sequences.
- Maps letter scan codes to a 0-25 index; Enter, Backspace and Escape map to command types.
- Presents one event at a time to the core over a valid/ready handshake, with overflow and timeout error reporting.

Parameters:
- TIMEOUT_CYC, 100000, clk cycles allowed in a prefix state with no following byte before the FSM aborts to IDLE (2 ms at 50 MHz).
- TMO_W, 17, width of the timeout counter; must satisfy 2**TMO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous active-high reset.
- key_rdy  in  1  one-cycle pulse from the ps2 receiver; key_out is valid in that cycle.
- key_out  in  8  received scan-code byte.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the event on a cycle where evt_valid=1 and evt_ready=1.
- evt_type  out  2  event type: 0=letter, 1=enter, 2=backspace, 3=escape.
- evt_idx  out  5  letter index, A=0 … Z=25; 0 for non-letter events.
- ovf  out  1  sticky flag: an event was dropped because the output register was full.
- tmo_err  out  1  one-cycle pulse when a prefix sequence times out.

Behaviour:
- Reset (rst=1 at a clk edge):
  - evt_valid=0, evt_type=0, evt_idx=0, ovf=0, tmo_err=0.
  - FSM=IDLE, timeout counter=0, held-key register cleared.
  - rst overrides a key_rdy in the same cycle; that byte is lost.
- FSM states: IDLE, EXT, BRK, EXT_BRK. Transitions occur only on key_rdy=1, except timeout:
  - IDLE: E0→EXT; F0→BRK; any other byte→decode as make, stay IDLE.
  - EXT: F0→EXT_BRK; any other byte→discard (extended make ignored), go to IDLE.
  - BRK: any byte→break of that code, go to IDLE; no event emitted.
  - EXT_BRK: any byte→discard, go to IDLE.
- Decode table (make in IDLE only):
  - Letters: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M, 31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
  - Commands: 5A→enter, 66→backspace, 76→escape.
  - All other codes, including AA and FA, are discarded silently.
- Latency: a decodable make with key_rdy high at edge N gives evt_valid=1 with type/idx stable at N+1.
- Output register (1 entry):
  - evt_type and evt_idx hold while evt_valid=1 and evt_ready=0.
  - Handshake completes at an edge with evt_valid & evt_ready; evt_valid clears next cycle unless a new event loads in the same edge.
  - New event with register empty, or draining in the same cycle (evt_valid & evt_ready): load; evt_valid stays 1.
  - New event with evt_valid=1 & evt_ready=0: drop the new event, keep the old one, set ovf=1.
  - ovf clears only on rst.
- Timeout:
  - Counter is cleared in IDLE and on every key_rdy.
  - Counter increments each cycle in EXT, BRK or EXT_BRK.
  - When the counter reaches TIMEOUT_CYC-1: FSM→IDLE, tmo_err pulses for 1 cycle, counter clears.
  - key_rdy in the same cycle as expiry has priority: the byte is processed normally and no tmo_err is raised.
- key_rdy is a pulse; a held-high input is treated as one byte per cycle and no filtering is done.

Optional Feature:
- Macro: PS2_REPEAT_FILTER_EN.
- Defined:
  - An 8-bit held register plus a held_vld bit record the last decodable make.
  - A make equal to the held code while held_vld=1 is suppressed: no event, no ovf.
  - A break (BRK path) of the held code clears held_vld.
  - A different decodable make emits normally and replaces the held code.
  - Reset clears held_vld.
- Undefined: every decodable make emits an event (typematic repeats pass through); the held register is not instantiated.

Test Plan:
- Bytes 1C, F0, 1C with evt_ready=1 → exactly one event, type=0, idx=0, one cycle after the first key_rdy; no event for the break; FSM back in IDLE.
- Bytes 15, 5A, 76, 66, 1A with evt_ready=1 → events (0,16), (1,0), (3,0), (2,0), (0,25) in order; ovf=0.
- Bytes E0, 5A, then E0, F0, 5A → no events; FSM returns to IDLE after each sequence.
- Byte F0, then no byte for TIMEOUT_CYC cycles → tmo_err pulses once; a following 1C yields event idx=0 (not treated as a break).
- evt_ready=0; bytes 1C then 32 → evt_idx stays 0 and ovf=1. Raise evt_ready for 1 cycle while 21 arrives in the same cycle → idx=2 loads with no extra drop and evt_valid stays 1.
- Bytes 1C, 1C, 1C, F0, 1C, 1C → with PS2_REPEAT_FILTER_EN: 2 events (idx 0, idx 0). Without the macro: 4 events. Assert rst mid-sequence after E0 → all outputs 0 and the next 1C produces idx 0.
